// File: rtl/mod_arith_pkg.sv
// Shared modular-arithmetic definitions.
//   mode_e   : operation select for add/sub blocks (MODE_ADD=0, MODE_SUB=1)
//   lane_lsb : LSB position of a lane inside a flat multi-lane bus
package mod_arith_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mod_addsub_lane.sv
// One lane of the modular add/sub datapath, purely combinational.
//   s1_* : stage-1 inputs (mode, m, a, b) -> W+1-bit raw sum/difference and range error
//   s2_* : stage-2 inputs (registered mode, m, raw, err) -> corrected result s2_c
module mod_addsub_lane
  import mod_arith_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  mode_e                 s1_mode,
  input  logic [DATA_WIDTH-1:0] s1_m,
  input  logic [DATA_WIDTH-1:0] s1_a,
  input  logic [DATA_WIDTH-1:0] s1_b,
  output logic [DATA_WIDTH:0]   s1_raw,
  output logic                  s1_err,
  input  mode_e                 s2_mode,
  input  logic [DATA_WIDTH-1:0] s2_m,
  input  logic [DATA_WIDTH:0]   s2_raw,
  input  logic                  s2_err,
  output logic [DATA_WIDTH-1:0] s2_c
);

  function automatic logic [DATA_WIDTH:0] raw_f(input mode_e mode,
                                                input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b);
    if (mode == MODE_SUB) return {1'b0, a} - {1'b0, b};
    else                  return {1'b0, a} + {1'b0, b};
  endfunction

  // ADD: subtract m once if raw >= m. SUB: bit W is the borrow, add m back.
  function automatic logic [DATA_WIDTH-1:0] correct_f(input mode_e mode,
                                                      input logic [DATA_WIDTH-1:0] m,
                                                      input logic [DATA_WIDTH:0] raw,
                                                      input logic err);
    logic [DATA_WIDTH:0] m_ext;
    logic [DATA_WIDTH:0] t;
    m_ext = {1'b0, m};
    if (mode == MODE_SUB) t = raw[DATA_WIDTH] ? (raw + m_ext) : raw;
    else                  t = (raw >= m_ext) ? (raw - m_ext) : raw;
    if (err) t = '0;
    return t[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    s1_raw = raw_f(s1_mode, s1_a, s1_b);
    s1_err = (s1_a >= s1_m) | (s1_b >= s1_m) | (s1_m == '0);
    s2_c   = correct_f(s2_mode, s2_m, s2_raw, s2_err);
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Pipelined multi-lane modular adder/subtractor: c = (a +/- b) mod m.
//   in_valid/in_ready   : input beat handshake (in_mode, in_m, in_a, in_b)
//   out_valid/out_ready : result beat handshake (out_c, out_err)
//   Lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH] of in_a, in_b and out_c.
//   Two register stages, latency 2, full throughput, backpressure via ready.
module mod_addsub_pipe
  import mod_arith_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  mode_e                       in_mode,
  input  logic [DATA_WIDTH-1:0]       in_m,
  input  logic [LANES*DATA_WIDTH-1:0] in_a,
  input  logic [LANES*DATA_WIDTH-1:0] in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_c,
  output logic [LANES-1:0]            out_err
);

  logic                             s1_valid_q, s1_valid_d;
  logic [LANES-1:0][DATA_WIDTH:0]   s1_raw_q, s1_raw_d;
  logic [DATA_WIDTH-1:0]            s1_m_q, s1_m_d;
  mode_e                            s1_mode_q, s1_mode_d;
  logic [LANES-1:0]                 s1_err_q, s1_err_d;
  logic                             s2_valid_q, s2_valid_d;
  logic [LANES*DATA_WIDTH-1:0]      out_c_q, out_c_d;
  logic [LANES-1:0]                 out_err_q, out_err_d;

  logic [LANES-1:0][DATA_WIDTH:0]   raw_lane;
  logic [LANES-1:0]                 err_lane;
  logic [LANES*DATA_WIDTH-1:0]      c_flat;
  logic                             s1_adv, s2_adv;

  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    mod_addsub_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .s1_mode (in_mode),
      .s1_m    (in_m),
      .s1_a    (in_a[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .s1_b    (in_b[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .s1_raw  (raw_lane[i]),
      .s1_err  (err_lane[i]),
      .s2_mode (s1_mode_q),
      .s2_m    (s1_m_q),
      .s2_raw  (s1_raw_q[i]),
      .s2_err  (s1_err_q[i]),
      .s2_c    (c_flat[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

  always_comb begin
    // Ready ripples back from the output; in_valid never reaches out_valid combinationally.
    s2_adv     = !s2_valid_q | out_ready;
    s1_adv     = !s1_valid_q | s2_adv;

    s1_valid_d = s1_valid_q;
    s1_raw_d   = s1_raw_q;
    s1_m_d     = s1_m_q;
    s1_mode_d  = s1_mode_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    out_c_d    = out_c_q;
    out_err_d  = out_err_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_raw_d  = raw_lane;
        s1_m_d    = in_m;
        s1_mode_d = in_mode;
        s1_err_d  = err_lane;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_c_d   = c_flat;
        out_err_d = s1_err_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_raw_q   <= '0;
      s1_m_q     <= '0;
      s1_mode_q  <= MODE_ADD;
      s1_err_q   <= '0;
      s2_valid_q <= 1'b0;
      out_c_q    <= '0;
      out_err_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_raw_q   <= s1_raw_d;
      s1_m_q     <= s1_m_d;
      s1_mode_q  <= s1_mode_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      out_c_q    <= out_c_d;
      out_err_q  <= out_err_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_c     = out_c_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
module tb_mod_addsub_pipe;
  import mod_arith_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned L  = 2;
  localparam int unsigned W2 = 16;

  logic clk = 1'b0;
  logic rst;

  logic              in_valid, in_ready, out_valid, out_ready;
  mode_e             in_mode;
  logic [W-1:0]      in_m;
  logic [L*W-1:0]    in_a, in_b, out_c;
  logic [L-1:0]      out_err;

  logic              in_valid_w, in_ready_w, out_valid_w, out_ready_w;
  mode_e             in_mode_w;
  logic [W2-1:0]     in_m_w;
  logic [L*W2-1:0]   in_a_w, in_b_w, out_c_w;
  logic [L-1:0]      out_err_w;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  mod_addsub_pipe #(.DATA_WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_m(in_m),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_err(out_err)
  );

  mod_addsub_pipe #(.DATA_WIDTH(W2), .LANES(L)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_w), .in_ready(in_ready_w), .in_mode(in_mode_w), .in_m(in_m_w),
    .in_a(in_a_w), .in_b(in_b_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_c(out_c_w), .out_err(out_err_w)
  );

  // Reference: arithmetic on integers, errored lanes give 0.
  function automatic int unsigned ref_lane(input mode_e md, input int unsigned m,
                                           input int unsigned a, input int unsigned b);
    if (m == 0 || a >= m || b >= m) return 0;
    if (md == MODE_ADD) return (a + b) % m;
    return (a + m - b) % m;
  endfunction

  function automatic bit ref_err(input int unsigned m, input int unsigned a, input int unsigned b);
    return (m == 0) || (a >= m) || (b >= m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane 0 values first in the argument list; bus packs lane 1 in the upper half.
  task automatic drive8(input bit vld, input mode_e md, input int unsigned m,
                        input int unsigned a0, input int unsigned a1,
                        input int unsigned b0, input int unsigned b1);
    in_valid = vld;
    in_mode  = md;
    in_m     = W'(m);
    in_a     = {W'(a1), W'(a0)};
    in_b     = {W'(b1), W'(b0)};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive8(1'b0, MODE_ADD, 97, 0, 0, 0, 0);
    out_ready   = 1'b1;
    in_valid_w  = 1'b0;
    in_mode_w   = MODE_ADD;
    in_m_w      = '0;
    in_a_w      = '0;
    in_b_w      = '0;
    out_ready_w = 1'b1;
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if (out_c !== '0) begin miscompares++; $display("FAIL reset_out_c: got %h want 0", out_c); end
    vectors++;
    if (out_err !== '0) begin miscompares++; $display("FAIL reset_out_err: got %b want 00", out_err); end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_add();
    drive8(1'b1, MODE_ADD, 97, 60, 96, 50, 1);
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_latency: out_valid got %b want 0 one cycle after accept", out_valid); end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_c !== {8'd0, 8'd13} || out_err !== 2'b00) begin
      miscompares++;
      $display("FAIL add_result: got v=%b c=%h e=%b want v=1 c=000d e=00", out_valid, out_c, out_err);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_no_dup: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_sub();
    drive8(1'b1, MODE_SUB, 97, 5, 40, 10, 40);
    tick();
    drive8(1'b1, MODE_SUB, 97, 96, 0, 0, 96);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_c !== {8'd0, 8'd92} || out_err !== 2'b00) begin
      miscompares++;
      $display("FAIL sub_borrow: got v=%b c=%h e=%b want v=1 c=005c e=00", out_valid, out_c, out_err);
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_c !== {8'd1, 8'd96} || out_err !== 2'b00) begin
      miscompares++;
      $display("FAIL sub_edges: got v=%b c=%h e=%b want v=1 c=0160 e=00", out_valid, out_c, out_err);
    end
    tick();
  endtask

  task automatic test_err();
    drive8(1'b1, MODE_ADD, 97, 97, 3, 1, 4);
    tick();
    drive8(1'b1, MODE_ADD, 0, 3, 4, 1, 2);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_c !== {8'd7, 8'd0} || out_err !== 2'b01) begin
      miscompares++;
      $display("FAIL err_lane0: got v=%b c=%h e=%b want v=1 c=0700 e=01", out_valid, out_c, out_err);
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_c !== 16'h0000 || out_err !== 2'b11) begin
      miscompares++;
      $display("FAIL err_m_zero: got v=%b c=%h e=%b want v=1 c=0000 e=11", out_valid, out_c, out_err);
    end
    tick();
  endtask

  task automatic test_backpressure();
    mode_e md[8];
    int unsigned a0[8], a1[8], b0[8], b1[8];
    logic [L*W-1:0] exp_c[8];
    logic [L-1:0]   exp_e[8];
    logic [L*W-1:0] hold_c;
    logic [L-1:0]   hold_e;
    int sent = 0, got = 0, cyc = 0;
    bit stalled_prev = 0, saw_block = 0, exp_ready;
    for (int i = 0; i < 8; i++) begin
      md[i] = mode_e'($urandom_range(0, 1));
      a0[i] = $urandom_range(0, 96); a1[i] = $urandom_range(0, 96);
      b0[i] = $urandom_range(0, 96); b1[i] = $urandom_range(0, 96);
      exp_c[i] = {W'(ref_lane(md[i], 97, a1[i], b1[i])), W'(ref_lane(md[i], 97, a0[i], b0[i]))};
      exp_e[i] = 2'b00;
    end
    hold_c = '0;
    hold_e = '0;
    while (got < 8 && cyc < 60) begin
      if (sent < 8) drive8(1'b1, md[sent], 97, a0[sent], a1[sent], b0[sent], b1[sent]);
      else in_valid = 1'b0;
      out_ready = !(cyc >= 3 && cyc < 6);
      #1;
      if (stalled_prev) begin
        vectors++;
        if (out_valid !== 1'b1 || out_c !== hold_c || out_err !== hold_e) begin
          miscompares++;
          $display("FAIL bp_stall_hold: got v=%b c=%h e=%b want v=1 c=%h e=%b", out_valid, out_c, out_err, hold_c, hold_e);
        end
      end
      exp_ready = !((sent - got) == 2 && !out_ready);
      vectors++;
      if (in_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL bp_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_ready);
      end
      if (in_ready === 1'b0) saw_block = 1;
      if (out_valid === 1'b1 && out_ready) begin
        vectors++;
        if (out_c !== exp_c[got] || out_err !== exp_e[got]) begin
          miscompares++;
          $display("FAIL bp_result %0d: got c=%h e=%b want c=%h e=%b", got, out_c, out_err, exp_c[got], exp_e[got]);
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) sent++;
      stalled_prev = (out_valid === 1'b1) && !out_ready;
      hold_c = out_c;
      hold_e = out_err;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (got != 8) begin miscompares++; $display("FAIL bp_count: got %0d results want 8", got); end
    vectors++;
    if (!saw_block) begin miscompares++; $display("FAIL bp_in_ready_drop: in_ready never 0 want 0 during stall"); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [L*W-1:0] exp_c[100];
    mode_e md[100];
    int unsigned a0[100], a1[100], b0[100], b1[100];
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1;
    for (int i = 0; i < 100; i++) begin
      md[i] = mode_e'($urandom_range(0, 1));
      a0[i] = $urandom_range(0, 96); a1[i] = $urandom_range(0, 96);
      b0[i] = $urandom_range(0, 96); b1[i] = $urandom_range(0, 96);
      exp_c[i] = {W'(ref_lane(md[i], 97, a1[i], b1[i])), W'(ref_lane(md[i], 97, a0[i], b0[i]))};
    end
    out_ready = 1'b1;
    while (got < 100 && cyc < 130) begin
      if (sent < 100) drive8(1'b1, md[sent], 97, a0[sent], a1[sent], b0[sent], b1[sent]);
      else in_valid = 1'b0;
      #1;
      if (sent < 100) begin
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready cyc %0d: got %b want 1", cyc, in_ready); end
      end
      if (out_valid === 1'b1) begin
        vectors++;
        if (out_c !== exp_c[got] || out_err !== 2'b00) begin
          miscompares++;
          $display("FAIL b2b_result %0d: got c=%h e=%b want c=%h e=00", got, out_c, out_err, exp_c[got]);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (in_valid && in_ready === 1'b1) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (got != 100) begin miscompares++; $display("FAIL b2b_count: got %0d want 100", got); end
    vectors++;
    if (first != 2 || last != 101) begin
      miscompares++;
      $display("FAIL b2b_timing: got first=%0d last=%0d want first=2 last=101", first, last);
    end
  endtask

  task automatic test_reset_flight();
    out_ready = 1'b0;
    drive8(1'b1, MODE_ADD, 97, 10, 20, 30, 40);
    tick();
    drive8(1'b1, MODE_SUB, 97, 1, 2, 3, 4);
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_c !== {8'd60, 8'd40}) begin
      miscompares++;
      $display("FAIL rstf_pre: got v=%b c=%h want v=1 c=3c28", out_valid, out_c);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_c !== '0 || out_err !== '0) begin
      miscompares++;
      $display("FAIL rstf_async: got v=%b c=%h e=%b want v=0 c=0000 e=00", out_valid, out_c, out_err);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstf_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstf_stale %0d: out_valid got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_w16();
    localparam int unsigned M16 = 65521;
    logic [L*W2-1:0] exp_c[40];
    logic [L-1:0]    exp_e[40];
    logic [L*W2-1:0] va[40], vb[40];
    mode_e md[40];
    int unsigned a0, a1, b0, b1;
    int sent = 0, got = 0, cyc = 0;
    for (int i = 0; i < 40; i++) begin
      md[i] = mode_e'($urandom_range(0, 1));
      a0 = $urandom_range(0, M16 - 1); a1 = $urandom_range(0, M16 - 1);
      b0 = $urandom_range(0, M16 - 1); b1 = $urandom_range(0, M16 - 1);
      if (i % 8 == 3) a1 = $urandom_range(M16, 65535);
      if (i % 8 == 6) b0 = $urandom_range(M16, 65535);
      if (i == 10) begin a0 = M16 - 1; b0 = 1; end
      va[i] = {W2'(a1), W2'(a0)};
      vb[i] = {W2'(b1), W2'(b0)};
      exp_c[i] = {W2'(ref_lane(md[i], M16, a1, b1)), W2'(ref_lane(md[i], M16, a0, b0))};
      exp_e[i] = {ref_err(M16, a1, b1), ref_err(M16, a0, b0)};
    end
    out_ready_w = 1'b1;
    in_m_w = W2'(M16);
    while (got < 40 && cyc < 80) begin
      if (sent < 40) begin
        in_valid_w = 1'b1; in_mode_w = md[sent]; in_a_w = va[sent]; in_b_w = vb[sent];
      end else in_valid_w = 1'b0;
      #1;
      if (out_valid_w === 1'b1) begin
        vectors++;
        if (out_c_w !== exp_c[got] || out_err_w !== exp_e[got]) begin
          miscompares++;
          $display("FAIL w16_result %0d: got c=%h e=%b want c=%h e=%b", got, out_c_w, out_err_w, exp_c[got], exp_e[got]);
        end
        got++;
      end
      if (in_valid_w && in_ready_w === 1'b1) sent++;
      tick();
      cyc++;
    end
    in_valid_w = 1'b0;
    vectors++;
    if (got != 40) begin miscompares++; $display("FAIL w16_count: got %0d want 40", got); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_err();
    test_backpressure();
    test_back_to_back();
    test_reset_flight();
    test_w16();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
